l2_response_arbiter: RTL and testbench

L2_RESPONSE_ARBITER -- requirements
Module: l2_response_arbiter

---
 rtl/l2_response_arbiter.sv | 79 +++++++
 tb/tb_l2_response_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/l2_response_arbiter.sv
// l2_response_arbiter: round-robin merge of two 2-deep response FIFOs (src0 hits/acks, src1 fills) into one registered CPI output with valid/ready
module l2_response_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         src0_valid,
  output logic         src0_ready,
  input  logic         src0_status,
  input  logic [1:0]   src0_unit,
  input  logic [1:0]   src0_strand,
  input  logic [1:0]   src0_op,
  input  logic         src0_update,
  input  logic [1:0]   src0_way,
  input  logic [511:0] src0_data,
  input  logic         src1_valid,
  output logic         src1_ready,
  input  logic         src1_status,
  input  logic [1:0]   src1_unit,
  input  logic [1:0]   src1_strand,
  input  logic [1:0]   src1_op,
  input  logic         src1_update,
  input  logic [1:0]   src1_way,
  input  logic [511:0] src1_data,
  output logic         cpi_valid,
  output logic         cpi_status,
  output logic [1:0]   cpi_unit,
  output logic [1:0]   cpi_strand,
  output logic [1:0]   cpi_op,
  output logic         cpi_update,
  output logic [1:0]   cpi_way,
  output logic [511:0] cpi_data,
  input  logic         cpi_ready
);
  localparam int W = 522;
  logic [W-1:0] din [2];
  logic [W-1:0] mem [2][DEPTH];
  logic [1:0]   cnt [2];
  logic [1:0]   wp, rp, ne, rdy, enq, pop;
  logic [W-1:0] head, out_q;
  logic         last_grant, free, sel, deq;
  assign din[0] = {src0_status, src0_unit, src0_strand, src0_op, src0_update, src0_way, src0_data};
  assign din[1] = {src1_status, src1_unit, src1_strand, src1_op, src1_update, src1_way, src1_data};
  assign rdy = {cnt[1] != 2'(DEPTH), cnt[0] != 2'(DEPTH)};
  assign {src1_ready, src0_ready} = rdy;
  assign ne = {|cnt[1], |cnt[0]};
  assign enq = {src1_valid, src0_valid} & rdy;
  assign free = !cpi_valid || cpi_ready;
  assign sel = ne[1] && (!ne[0] || !last_grant);
  assign deq = free && |ne;
  assign pop = {deq && sel, deq && !sel};
  assign head = mem[sel][rp[sel]];
  assign {cpi_status, cpi_unit, cpi_strand, cpi_op, cpi_update, cpi_way, cpi_data} = out_q;
  always_ff @(posedge clk) begin
    if (enq[0]) mem[0][wp[0]] <= din[0];
    if (enq[1]) mem[1][wp[1]] <= din[1];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt[0]     <= '0;
      cnt[1]     <= '0;
      wp         <= '0;
      rp         <= '0;
      last_grant <= 1'b1;
      cpi_valid  <= 1'b0;
      out_q      <= '0;
    end else begin
      cnt[0] <= cnt[0] + 2'(enq[0]) - 2'(pop[0]);
      cnt[1] <= cnt[1] + 2'(enq[1]) - 2'(pop[1]);
      wp     <= wp ^ enq;
      rp     <= rp ^ pop;
      if (deq) begin
        out_q      <= head;
        cpi_valid  <= 1'b1;
        last_grant <= sel;
      end else if (free) cpi_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_l2_response_arbiter.sv
// tb_l2_response_arbiter: scoreboard bench for l2_response_arbiter; data bit 511 tags the source of each payload
module tb_l2_response_arbiter;
  logic clk = 0, reset_n = 1, s0_v = 0, s1_v = 0, cpi_ready = 0;
  logic [521:0] s0_pl = '0, s1_pl = '0, cpi_pl;
  logic src0_ready, src1_ready, cpi_valid, cpi_status, cpi_update;
  logic [1:0] cpi_unit, cpi_strand, cpi_op, cpi_way;
  logic [511:0] cpi_data;
  int checks = 0, errors = 0;
  logic [521:0] exp0[$], exp1[$], obs[$];
  always #5 clk = ~clk;
  assign cpi_pl = {cpi_status, cpi_unit, cpi_strand, cpi_op, cpi_update, cpi_way, cpi_data};
  l2_response_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .src0_valid(s0_v), .src0_ready(src0_ready),
    .src0_status(s0_pl[521]), .src0_unit(s0_pl[520:519]), .src0_strand(s0_pl[518:517]),
    .src0_op(s0_pl[516:515]), .src0_update(s0_pl[514]), .src0_way(s0_pl[513:512]), .src0_data(s0_pl[511:0]),
    .src1_valid(s1_v), .src1_ready(src1_ready),
    .src1_status(s1_pl[521]), .src1_unit(s1_pl[520:519]), .src1_strand(s1_pl[518:517]),
    .src1_op(s1_pl[516:515]), .src1_update(s1_pl[514]), .src1_way(s1_pl[513:512]), .src1_data(s1_pl[511:0]),
    .cpi_valid(cpi_valid), .cpi_status(cpi_status), .cpi_unit(cpi_unit), .cpi_strand(cpi_strand),
    .cpi_op(cpi_op), .cpi_update(cpi_update), .cpi_way(cpi_way), .cpi_data(cpi_data),
    .cpi_ready(cpi_ready)
  );
  always @(negedge clk) if (reset_n && cpi_valid && cpi_ready) obs.push_back(cpi_pl);
  function automatic logic [521:0] mk(input bit src, input int tag);
    return {1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
            src, 447'b0, 32'(tag), 32'($urandom)};
  endfunction
  task automatic step();
    if (s0_v && src0_ready) exp0.push_back(s0_pl);
    if (s1_v && src1_ready) exp1.push_back(s1_pl);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    s0_v = 0;
    s1_v = 0;
    reset_n = 0;
    #2;
    reset_n = 1;
    exp0.delete();
    exp1.delete();
    obs.delete();
  endtask
  task automatic test_reset();
    #1 reset_n = 0;
    #1;
    checks++; if (cpi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", cpi_valid); end
    checks++; if (cpi_pl !== '0) begin errors++; $display("FAIL reset_payload: got %h exp 0", cpi_pl); end
    checks++; if ({src1_ready, src0_ready} !== 2'b11) begin errors++; $display("FAIL reset_ready: got %b exp 11", {src1_ready, src0_ready}); end
    @(posedge clk);
    #1;
    reset_n = 1;
    checks++; if (dut.cnt[0] !== 2'd0 || dut.cnt[1] !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d %0d exp 0 0", dut.cnt[0], dut.cnt[1]); end
  endtask
  task automatic test_single();
    logic [521:0] p, o, e;
    cpi_ready = 1;
    p = mk(0, 1);
    p[516:515] = 2'd1;
    p[520:519] = 2'd2;
    s0_pl = p;
    s0_v = 1;
    step();
    s0_v = 0;
    checks++; if (cpi_valid !== 1'b0) begin errors++; $display("FAIL single_bypass: cpi_valid got %b exp 0", cpi_valid); end
    step();
    checks++; if (cpi_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", cpi_valid); end
    checks++; if (cpi_op !== 2'd1 || cpi_unit !== 2'd2) begin errors++; $display("FAIL single_fields: op %0d unit %0d exp 1 2", cpi_op, cpi_unit); end
    checks++; if (cpi_data !== p[511:0]) begin errors++; $display("FAIL single_data: got %h exp %h", cpi_data, p[511:0]); end
    step();
    checks++; if (cpi_valid !== 1'b0) begin errors++; $display("FAIL single_idle: cpi_valid got %b exp 0", cpi_valid); end
    checks++; if (cpi_data !== p[511:0]) begin errors++; $display("FAIL single_hold: data got %h exp %h", cpi_data, p[511:0]); end
    while (obs.size() > 0) begin
      o = obs.pop_front();
      checks++;
      if (o[511] ? exp1.size() == 0 : exp0.size() == 0) begin errors++; $display("FAIL single_sb: unexpected output %h", o); end
      else begin e = o[511] ? exp1.pop_front() : exp0.pop_front(); if (o !== e) begin errors++; $display("FAIL single_sb: got %h exp %h", o, e); end end
    end
    checks++; if (exp0.size() + exp1.size() != 0) begin errors++; $display("FAIL single_lost: %0d entries not emitted exp 0", exp0.size() + exp1.size()); end
  endtask
  task automatic test_tie();
    logic [521:0] a, b, o, e;
    do_reset();
    cpi_ready = 1;
    a = mk(0, 2);
    b = mk(1, 3);
    s0_pl = a;
    s1_pl = b;
    s0_v = 1;
    s1_v = 1;
    step();
    s0_v = 0;
    s1_v = 0;
    step();
    checks++; if (cpi_valid !== 1'b1 || cpi_pl !== a) begin errors++; $display("FAIL tie_first: valid %b got %h exp %h", cpi_valid, cpi_pl, a); end
    step();
    checks++; if (cpi_valid !== 1'b1 || cpi_pl !== b) begin errors++; $display("FAIL tie_second: valid %b got %h exp %h", cpi_valid, cpi_pl, b); end
    step();
    checks++; if (cpi_valid !== 1'b0) begin errors++; $display("FAIL tie_idle: cpi_valid got %b exp 0", cpi_valid); end
    while (obs.size() > 0) begin
      o = obs.pop_front();
      checks++;
      if (o[511] ? exp1.size() == 0 : exp0.size() == 0) begin errors++; $display("FAIL tie_sb: unexpected output %h", o); end
      else begin e = o[511] ? exp1.pop_front() : exp0.pop_front(); if (o !== e) begin errors++; $display("FAIL tie_sb: got %h exp %h", o, e); end end
    end
    checks++; if (exp0.size() + exp1.size() != 0) begin errors++; $display("FAIL tie_lost: %0d entries not emitted exp 0", exp0.size() + exp1.size()); end
  endtask
  task automatic test_back_to_back();
    logic [521:0] o, e;
    int n, c1;
    do_reset();
    cpi_ready = 1;
    s0_v = 1;
    s1_v = 1;
    for (int k = 0; k < 24; k++) begin
      s0_pl = mk(0, 100 + k);
      s1_pl = mk(1, 200 + k);
      step();
    end
    s0_v = 0;
    s1_v = 0;
    n = obs.size();
    c1 = 0;
    checks++; if (n < 20) begin errors++; $display("FAIL b2b_rate: %0d outputs in window exp >= 20", n); end
    for (int i = 0; i < n; i++) begin
      c1 += int'(obs[i][511]);
      checks++; if (obs[i][511] !== 1'(i % 2)) begin errors++; $display("FAIL b2b_alt: output %0d from src%0d exp src%0d", i, obs[i][511], i % 2); end
    end
    checks++; if (c1 != n / 2) begin errors++; $display("FAIL b2b_share: src1 got %0d of %0d exp %0d", c1, n, n / 2); end
    for (int k = 0; k < 8; k++) step();
    while (obs.size() > 0) begin
      o = obs.pop_front();
      checks++;
      if (o[511] ? exp1.size() == 0 : exp0.size() == 0) begin errors++; $display("FAIL b2b_sb: unexpected output %h", o); end
      else begin e = o[511] ? exp1.pop_front() : exp0.pop_front(); if (o !== e) begin errors++; $display("FAIL b2b_sb: got %h exp %h", o, e); end end
    end
    checks++; if (exp0.size() + exp1.size() != 0) begin errors++; $display("FAIL b2b_lost: %0d entries not emitted exp 0", exp0.size() + exp1.size()); end
  endtask
  task automatic test_backpressure();
    logic [521:0] a, o, e;
    int got;
    do_reset();
    cpi_ready = 0;
    a = mk(0, 10);
    s0_pl = a;
    s0_v = 1;
    step();
    s0_pl = mk(0, 11);
    step();
    checks++; if (cpi_valid !== 1'b1 || cpi_pl !== a) begin errors++; $display("FAIL bp_present: valid %b got %h exp %h", cpi_valid, cpi_pl, a); end
    s0_pl = mk(0, 12);
    step();
    s0_pl = mk(0, 13);
    checks++; if (src0_ready !== 1'b0) begin errors++; $display("FAIL bp_full: src0_ready got %b exp 0", src0_ready); end
    step();
    step();
    checks++; if (src0_ready !== 1'b0 || dut.cnt[0] !== 2'd2) begin errors++; $display("FAIL bp_stall: ready %b count %0d exp 0 2", src0_ready, dut.cnt[0]); end
    checks++; if (cpi_valid !== 1'b1 || cpi_pl !== a) begin errors++; $display("FAIL bp_hold: valid %b got %h exp %h", cpi_valid, cpi_pl, a); end
    cpi_ready = 1;
    for (int k = 0; k < 10 && s0_v; k++) begin
      if (src0_ready) begin step(); s0_v = 0; end else step();
    end
    checks++; if (s0_v !== 1'b0) begin errors++; $display("FAIL bp_timeout: D never accepted within 10 cycles"); s0_v = 0; end
    for (int k = 0; k < 6; k++) step();
    got = obs.size();
    checks++; if (got != 4) begin errors++; $display("FAIL bp_count: %0d outputs exp 4", got); end
    while (obs.size() > 0) begin
      o = obs.pop_front();
      checks++;
      if (o[511] ? exp1.size() == 0 : exp0.size() == 0) begin errors++; $display("FAIL bp_sb: unexpected output %h", o); end
      else begin e = o[511] ? exp1.pop_front() : exp0.pop_front(); if (o !== e) begin errors++; $display("FAIL bp_sb: got %h exp %h", o, e); end end
    end
    checks++; if (exp0.size() + exp1.size() != 0) begin errors++; $display("FAIL bp_lost: %0d entries not emitted exp 0", exp0.size() + exp1.size()); end
  endtask
  task automatic test_simul();
    logic [521:0] o, e;
    do_reset();
    cpi_ready = 1;
    s0_v = 1;
    for (int k = 0; k < 6; k++) begin
      s0_pl = mk(0, 20 + k);
      step();
      checks++; if (dut.cnt[0] !== 2'd1) begin errors++; $display("FAIL simul_cnt: cycle %0d count %0d exp 1", k, dut.cnt[0]); end
    end
    s0_v = 0;
    for (int k = 0; k < 4; k++) step();
    while (obs.size() > 0) begin
      o = obs.pop_front();
      checks++;
      if (o[511] ? exp1.size() == 0 : exp0.size() == 0) begin errors++; $display("FAIL simul_sb: unexpected output %h", o); end
      else begin e = o[511] ? exp1.pop_front() : exp0.pop_front(); if (o !== e) begin errors++; $display("FAIL simul_sb: got %h exp %h", o, e); end end
    end
    checks++; if (exp0.size() + exp1.size() != 0) begin errors++; $display("FAIL simul_lost: %0d entries not emitted exp 0", exp0.size() + exp1.size()); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    cpi_ready = 0;
    s0_v = 1;
    s1_v = 1;
    for (int k = 0; k < 4; k++) begin
      s0_pl = mk(0, 30 + k);
      s1_pl = mk(1, 40 + k);
      step();
    end
    checks++; if ({cpi_valid, src1_ready, src0_ready} !== 3'b100) begin errors++; $display("FAIL mid_full: valid/rdy1/rdy0 got %b exp 100", {cpi_valid, src1_ready, src0_ready}); end
    #2;
    reset_n = 0;
    #1;
    checks++; if (cpi_valid !== 1'b0 || cpi_pl !== '0) begin errors++; $display("FAIL mid_clear: valid %b payload %h exp 0 0", cpi_valid, cpi_pl); end
    checks++; if ({src1_ready, src0_ready} !== 2'b11) begin errors++; $display("FAIL mid_ready: got %b exp 11", {src1_ready, src0_ready}); end
    s0_v = 0;
    s1_v = 0;
    exp0.delete();
    exp1.delete();
    obs.delete();
    #1;
    reset_n = 1;
    cpi_ready = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (cpi_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: cycle %0d cpi_valid %b exp 0", k, cpi_valid); end
    end
    checks++; if (obs.size() != 0) begin errors++; $display("FAIL mid_emit: %0d stale outputs exp 0", obs.size()); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_backpressure();
    test_simul();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
